// File: rtl/fft_bfly_sched_if.sv
// fft_bfly_sched_if: bundles the input stream, output stream, external
// add/sub operand/result wires and status flags of one butterfly stage.
//
// Stream handshakes (in_* and out_*): a transfer happens on a rising edge
// where valid and ready are both high. The source holds valid and data
// stable until that transfer; valid is ignored while ready is low and
// ready is ignored while valid is low.
interface fft_bfly_sched_if #(
    parameter int N = 3
);
    localparam int W = 2 ** N;

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    logic         as_add;
    logic [W-1:0] as_a;
    logic [W-1:0] as_b;
    logic [W-1:0] as_result;

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    logic         busy;
    logic         done;

    // Butterfly stage side
    modport slave (
        input  in_valid, in_data, as_result, out_ready,
        output in_ready, as_add, as_a, as_b, out_valid, out_data, busy, done
    );

    // Environment side: sample source, add/sub unit and sample sink
    modport master (
        output in_valid, in_data, as_result, out_ready,
        input  in_ready, as_add, as_a, as_b, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched: one radix-2 butterfly stage of an 8-point FFT, time-shared
// over a single external add/sub unit. Each frame runs LOAD (8 samples in),
// CALC (4 pairs, add cycle then subtract cycle) and DRAIN (8 results out).
module fft_bfly_sched #(
    parameter int N    = 3,
    parameter int SPAN = 1   // butterfly distance: 1, 2 or 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_bfly_sched_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    localparam int W = 2 ** N;
    localparam logic [2:0] SPAN_L   = 3'(SPAN);
    localparam logic [2:0] STRIDE_L = 3'(2 * SPAN);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         done_q, done_d;
    logic [W-1:0] ibuf_q [8];
    logic [W-1:0] obuf_q [8];

    logic         in_fire;
    logic         out_fire;
    logic [2:0]   pair_k;
    logic [2:0]   idx_i;
    logic [2:0]   idx_j;
    logic [2:0]   wr_idx;

    assign in_fire  = (state_q == S_LOAD) && in_ready_q && bus.in_valid;
    assign out_fire = (state_q == S_DRAIN) && bus.out_ready;

    // Pair schedule: CALC cycle cnt serves pair k = cnt/2 on indices (i, i+SPAN);
    // the even cycle produces the sum for i, the odd cycle the difference for j.
    always_comb begin
        pair_k = {1'b0, cnt_q[2:1]};
        idx_i  = ((pair_k / SPAN_L) * STRIDE_L) + (pair_k % SPAN_L);
        idx_j  = idx_i + SPAN_L;
        wr_idx = cnt_q[0] ? idx_j : idx_i;
    end

    // Next-state logic and all combinational outputs of the frame sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        in_ready_d    = 1'b0;
        bus.as_add    = 1'b1;
        bus.as_a      = '0;
        bus.as_b      = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.busy      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                bus.busy   = 1'b1;
                bus.as_add = ~cnt_q[0];
                bus.as_a   = ibuf_q[idx_i];
                bus.as_b   = ibuf_q[idx_j];
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = obuf_q[cnt_q];
                if (out_fire) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_LOAD;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
        // Registered so it reads 0 in the cycle right after a reset edge and
        // rises together with done when a frame completes.
        in_ready_d = (state_d == S_LOAD);
    end

    // Control state register; any reset aborts the frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // Sample and result buffers; every entry is rewritten before it is read in a frame.
    always_ff @(posedge clk) begin
        if (rst_n && in_fire) begin
            ibuf_q[cnt_q] <= bus.in_data;
        end
        if (rst_n && (state_q == S_CALC)) begin
            obuf_q[wr_idx] <= bus.as_result;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_fft_bfly_sched.sv
// tb_fft_bfly_sched: three stages (SPAN 1, 2, 4) run in lockstep on shared
// stimulus; each lane is checked against a butterfly model of its span.
module tb_fft_bfly_sched;
    localparam int N = 3;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic [1:0]   dbg0, dbg1, dbg2;

    fft_bfly_sched_if #(.N(N)) bus0 ();
    fft_bfly_sched_if #(.N(N)) bus1 ();
    fft_bfly_sched_if #(.N(N)) bus2 ();

    fft_bfly_sched #(.N(N), .SPAN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state_o(dbg0));
    fft_bfly_sched #(.N(N), .SPAN(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state_o(dbg1));
    fft_bfly_sched #(.N(N), .SPAN(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state_o(dbg2));

    // shared stream inputs and a behavioural add/sub unit per lane
    assign bus0.in_valid  = in_valid;
    assign bus1.in_valid  = in_valid;
    assign bus2.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus1.in_data   = in_data;
    assign bus2.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;
    assign bus2.out_ready = out_ready;
    assign bus0.as_result = bus0.as_add ? bus0.as_a + bus0.as_b : bus0.as_a - bus0.as_b;
    assign bus1.as_result = bus1.as_add ? bus1.as_a + bus1.as_b : bus1.as_a - bus1.as_b;
    assign bus2.as_result = bus2.as_add ? bus2.as_a + bus2.as_b : bus2.as_a - bus2.as_b;

    logic [2:0]   l_in_ready, l_out_valid, l_as_add, l_busy, l_done;
    logic [W-1:0] l_out_data [3];
    logic [W-1:0] l_as_a [3];
    logic [W-1:0] l_as_b [3];
    assign l_in_ready  = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign l_out_valid = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign l_as_add    = {bus2.as_add, bus1.as_add, bus0.as_add};
    assign l_busy      = {bus2.busy, bus1.busy, bus0.busy};
    assign l_done      = {bus2.done, bus1.done, bus0.done};
    assign l_out_data[0] = bus0.out_data;
    assign l_out_data[1] = bus1.out_data;
    assign l_out_data[2] = bus2.out_data;
    assign l_as_a[0] = bus0.as_a;
    assign l_as_a[1] = bus1.as_a;
    assign l_as_a[2] = bus2.as_a;
    assign l_as_b[0] = bus0.as_b;
    assign l_as_b[1] = bus1.as_b;
    assign l_as_b[2] = bus2.as_b;

    int checks = 0;
    int errors = 0;
    logic [3*W-1:0] exp_q[$];   // {lane2, lane1, lane0} per output index
    bit             hold_valid = 1'b0;
    logic [W-1:0]   hold_data  = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Butterfly model: index idx pairs with idx^span; the lower index gets the sum,
    // the upper gets lower minus upper, all modulo 2**W.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] x[8], input int span, input int idx);
        logic [W-1:0] r;
        int p;
        p = idx ^ span;
        if ((idx & span) == 0) r = x[idx] + x[p];
        else                   r = x[p] - x[idx];
        return r;
    endfunction

    task automatic push_expected(input logic [W-1:0] x[8]);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({ref_out(x, 4, i), ref_out(x, 2, i), ref_out(x, 1, i)});
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (l_in_ready[d] !== 1'b0 || l_out_valid[d] !== 1'b0 || l_out_data[d] !== '0 ||
                l_as_add[d] !== 1'b1 || l_as_a[d] !== '0 || l_as_b[d] !== '0 ||
                l_busy[d] !== 1'b0 || l_done[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s lane%0d got rdy=%b vld=%b data=%0d add=%b a=%0d b=%0d busy=%b done=%b want 0 0 0 1 0 0 0 0",
                         tag, d, l_in_ready[d], l_out_valid[d], l_out_data[d], l_as_add[d],
                         l_as_a[d], l_as_b[d], l_busy[d], l_done[d]);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (l_in_ready !== 3'b111 || l_done !== 3'b000 || l_busy !== 3'b000 || l_out_valid !== 3'b000) begin
            errors++;
            $display("FAIL %s got rdy=%b done=%b busy=%b vld=%b want 111 000 000 000",
                     tag, l_in_ready, l_done, l_busy, l_out_valid);
        end
    endtask

    // driver: present x[start..7]; optional random bubbles on in_valid
    task automatic load_frame(input logic [W-1:0] x[8], input int start, input bit gaps);
        int n;
        int guard;
        n = start;
        guard = 0;
        while (n < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            checks++;
            if (l_in_ready !== 3'b111 || l_done !== 3'b000 || l_busy !== 3'b000) begin
                errors++;
                $display("FAIL load_state n=%0d got rdy=%b done=%b busy=%b want 111 000 000",
                         n, l_in_ready, l_done, l_busy);
            end
            out_ready = 1'($urandom_range(0, 1));
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
            end else begin
                in_valid = 1'b1;
                in_data  = x[n];
                n++;
            end
        end
        if (n < 8) begin
            errors++;
            $display("FAIL load_timeout got %0d samples want 8", n);
        end
    endtask

    // monitor for the 8 CALC cycles following the last input handshake
    task automatic check_calc(input logic [W-1:0] x[8]);
        int tops[$];
        int span;
        int top;
        logic exp_add;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                span = 1 << d;
                tops.delete();
                for (int i = 0; i < 8; i++) begin
                    if ((i & span) == 0) tops.push_back(i);
                end
                top = tops[c / 2];
                exp_add = (c % 2 == 0);
                checks++;
                if (l_as_add[d] !== exp_add || l_as_a[d] !== x[top] || l_as_b[d] !== x[top + span]) begin
                    errors++;
                    $display("FAIL sched lane%0d cyc%0d got add=%b a=%0d b=%0d want add=%b a=%0d b=%0d",
                             d, c, l_as_add[d], l_as_a[d], l_as_b[d], exp_add, x[top], x[top + span]);
                end
                checks++;
                if (l_busy[d] !== 1'b1 || l_out_valid[d] !== 1'b0 || l_in_ready[d] !== 1'b0 || l_done[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL calc_state lane%0d cyc%0d got busy=%b vld=%b rdy=%b done=%b want 1 0 0 0",
                             d, c, l_busy[d], l_out_valid[d], l_in_ready[d], l_done[d]);
                end
            end
            checks++;
            if (dbg1 !== dbg0 || dbg2 !== dbg0) begin
                errors++;
                $display("FAIL dbg_lockstep got %0d %0d %0d want all equal", dbg0, dbg1, dbg2);
            end
            out_ready = 1'($urandom_range(0, 1));
            if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = hold_data;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // sink + scoreboard: mode 0 always ready, 1 toggling, 2 random
    task automatic drain_frame(input int mode, input int n_take);
        int got;
        int guard;
        bit stalled;
        logic [3*W-1:0] cur, prev, want;
        got = 0;
        guard = 0;
        stalled = 1'b0;
        prev = '0;
        while (got < n_take && guard < 100) begin
            @(negedge clk);
            guard++;
            cur = {l_out_data[2], l_out_data[1], l_out_data[0]};
            checks++;
            if (l_out_valid !== 3'b111 || l_busy !== 3'b111 || l_in_ready !== 3'b000) begin
                errors++;
                $display("FAIL drain_state idx%0d got vld=%b busy=%b rdy=%b want 111 111 000",
                         got, l_out_valid, l_busy, l_in_ready);
            end
            if (stalled) begin
                checks++;
                if (cur !== prev) begin
                    errors++;
                    $display("FAIL stall_hold idx%0d got %h want %h", got, cur, prev);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty idx%0d got %h want queued value", got, cur);
            end else begin
                want = exp_q[0];
                for (int d = 0; d < 3; d++) begin
                    if (d > 0) checks++;
                    if (cur[d*W +: W] !== want[d*W +: W]) begin
                        errors++;
                        $display("FAIL out_data lane%0d idx%0d got %0d want %0d",
                                 d, got, cur[d*W +: W], want[d*W +: W]);
                    end
                end
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (guard % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!hold_valid) in_valid = 1'b0;
            if (out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            prev = cur;
        end
        if (got < n_take) begin
            errors++;
            $display("FAIL drain_timeout got %0d handshakes want %0d", got, n_take);
        end
        if (n_take == 8) begin
            @(negedge clk);
            checks++;
            if (l_done !== 3'b111 || l_in_ready !== 3'b111 || l_out_valid !== 3'b000 || l_busy !== 3'b000) begin
                errors++;
                $display("FAIL done_pulse got done=%b rdy=%b vld=%b busy=%b want 111 111 000 000",
                         l_done, l_in_ready, l_out_valid, l_busy);
            end
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_frame(input logic [W-1:0] x[8], input int mode, input bit gaps);
        push_expected(x);
        load_frame(x, 0, gaps);
        check_calc(x);
        drain_frame(mode, 8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (l_in_ready !== 3'b111 || l_done !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got rdy=%b done=%b want 111 000", l_in_ready, l_done);
        end
    endtask

    task automatic test_ramp();
        logic [W-1:0] x[8];
        for (int i = 0; i < 8; i++) x[i] = 8'(i);
        run_frame(x, 0, 1'b0);
        check_idle("ramp_after_done");
    endtask

    task automatic test_decades();
        logic [W-1:0] x[8];
        for (int i = 0; i < 8; i++) x[i] = 8'(10 * (i + 1));
        run_frame(x, 0, 1'b1);
        check_idle("decades_after_done");
    endtask

    task automatic test_wrap();
        logic [W-1:0] x[8];
        for (int i = 0; i < 8; i++) x[i] = (i % 2 == 0) ? 8'd200 : 8'd100;
        run_frame(x, 0, 1'b0);
        check_idle("wrap_after_done");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x[8];
        for (int i = 0; i < 8; i++) x[i] = 8'(i);
        run_frame(x, 1, 1'b0);
        check_idle("backpressure_after_done");
    endtask

    task automatic test_abort();
        logic [W-1:0] x[8];
        for (int i = 0; i < 8; i++) x[i] = 8'(i);
        // abort in the third CALC cycle
        load_frame(x, 0, 1'b1);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("abort_calc");
        rst_n = 1'b1;
        check_idle("abort_calc_release");
        // abort after three DRAIN handshakes
        push_expected(x);
        load_frame(x, 0, 1'b0);
        check_calc(x);
        drain_frame(0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("abort_drain");
        exp_q.delete();
        rst_n = 1'b1;
        check_idle("abort_drain_release");
        run_frame(x, 0, 1'b0);
        check_idle("abort_refill_after_done");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a[8];
        logic [W-1:0] b[8];
        for (int i = 0; i < 8; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 255));
        end
        push_expected(a);
        load_frame(a, 0, 1'b0);
        hold_valid = 1'b1;
        hold_data  = b[0];
        check_calc(a);
        drain_frame(0, 8);   // b[0] is taken on the edge ending the done cycle
        hold_valid = 1'b0;
        push_expected(b);
        load_frame(b, 1, 1'b0);
        check_calc(b);
        drain_frame(0, 8);
        check_idle("b2b_after_done");
    endtask

    task automatic test_random();
        logic [W-1:0] x[8];
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) x[i] = 8'($urandom_range(0, 255));
            run_frame(x, 2, 1'b1);
        end
        check_idle("random_after_done");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_decades();
        test_wrap();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
